// File: rtl/fetch_predict.sv
// Fetch front end: owns the PC and a 4-entry 2-bit branch predictor table,
// and produces the fetch bundle that the IF/ID register captures.
module fetch_predict #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        resolve_valid,
  input  logic [1:0]  resolve_index,
  input  logic        resolve_taken,
  output logic        fetch_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [31:0] pc_x,
  output logic        branch,
  output logic        Pcsrc_P,
  output logic [1:0]  branch_add,
  output logic [1:0]  n_taken_data
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]  ctr [4];
  logic [1:0]  ctr_old;
  logic [1:0]  ctr_new;
  logic [31:0] imm;
  logic [31:0] pc_nxt;
  logic        unused_bits;

  assign unused_bits = ^instruction[24:12];

  assign imm = {{19{instruction[31]}}, instruction[31],
                instruction[7], instruction[30:25],
                instruction[11:8], 1'b0};

  assign pc_4         = pc + 32'd4;
  assign branch       = fetch_valid &
                        (instruction[6:0] == OP_BRANCH);
  assign pc_x         = branch ? pc + imm : 32'd0;
  assign branch_add   = pc[3:2];
  assign n_taken_data = ctr[branch_add];
  assign Pcsrc_P      = branch & n_taken_data[1];

  always_comb begin
    pc_nxt = pc_4;
    priority case (1'b1)
      redirect_valid: pc_nxt = redirect_pc;
      stall:          pc_nxt = pc;
      Pcsrc_P:        pc_nxt = pc_x;
      default:        pc_nxt = pc_4;
    endcase
  end

  // Saturating counter step for the resolved entry.
  always_comb begin
    ctr_old = ctr[resolve_index];
    ctr_new = ctr_old;
    if (resolve_taken) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'd1;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
    end else if (!fetch_valid) begin
      fetch_valid <= 1'b1;
    end else begin
      pc <= pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) ctr[i] <= 2'b01;
    end else if (resolve_valid) begin
      ctr[resolve_index] <= ctr_new;
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: stimulus pushes expected fetch
// bundles into a queue, a negedge monitor pops and compares them.
module tb_fetch_predict;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'h0020_8463;
  localparam logic [31:0] BWD = 32'hFE00_0EE3;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resolve_valid;
  logic [1:0]  resolve_index;
  logic        resolve_taken;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [31:0] pc_x;
  logic        branch;
  logic        Pcsrc_P;
  logic [1:0]  branch_add;
  logic [1:0]  n_taken_data;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pcx;
    logic        fv;
    logic        br;
    logic        ps;
    logic [1:0]  ba;
    logic [1:0]  nd;
  } exp_t;

  exp_t sb [$];

  fetch_predict #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .instruction    (instruction),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resolve_valid  (resolve_valid),
    .resolve_index  (resolve_index),
    .resolve_taken  (resolve_taken),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .pc_4           (pc_4),
    .pc_x           (pc_x),
    .branch         (branch),
    .Pcsrc_P        (Pcsrc_P),
    .branch_add     (branch_add),
    .n_taken_data   (n_taken_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(string n, string f, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", n, f, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "pc", pc, e.pc);
      cmp(e.name, "pc_4", pc_4, e.pc4);
      cmp(e.name, "pc_x", pc_x, e.pcx);
      cmp(e.name, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      cmp(e.name, "branch", {31'd0, branch}, {31'd0, e.br});
      cmp(e.name, "Pcsrc_P", {31'd0, Pcsrc_P}, {31'd0, e.ps});
      cmp(e.name, "branch_add", {30'd0, branch_add}, {30'd0, e.ba});
      cmp(e.name, "n_taken", {30'd0, n_taken_data}, {30'd0, e.nd});
    end
  end

  task automatic chk(string n, logic [31:0] p, logic [31:0] p4,
                     logic [31:0] px, logic fv, logic br, logic ps,
                     logic [1:0] ba, logic [1:0] nd);
    exp_t e;
    e.name = n; e.pc = p; e.pc4 = p4; e.pcx = px;
    e.fv = fv; e.br = br; e.ps = ps; e.ba = ba; e.nd = nd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(logic v, logic [31:0] a);
    redirect_valid = v;
    redirect_pc    = a;
  endtask

  task automatic res(logic v, logic [1:0] i, logic t);
    resolve_valid = v;
    resolve_index = i;
    resolve_taken = t;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    instruction = NOP;
    stall = 1'b0;
    redir(1'b0, 32'd0);
    res(1'b0, 2'd0, 1'b0);

    tick();
    rst = 1'b1;
    chk("rst_pre", 32'h100, 32'h104, 0, 0, 0, 0, 2'd0, 2'd1);
    tick();
    chk("start1", 32'h100, 32'h104, 0, 1, 0, 0, 2'd0, 2'd1);
    tick();
    chk("start2", 32'h104, 32'h108, 0, 1, 0, 0, 2'd1, 2'd1);
    tick();
    instruction = BEQ;
    chk("nt_pred", 32'h108, 32'h10C, 32'h110, 1, 1, 0, 2'd2, 2'd1);
    tick();
    instruction = NOP;
    res(1'b1, 2'd2, 1'b1);
    chk("nt_next", 32'h10C, 32'h110, 0, 1, 0, 0, 2'd3, 2'd1);
    tick();
    chk("train2", 32'h110, 32'h114, 0, 1, 0, 0, 2'd0, 2'd1);
    tick();
    res(1'b0, 2'd0, 1'b0);
    redir(1'b1, 32'h108);
    chk("to108", 32'h114, 32'h118, 0, 1, 0, 0, 2'd1, 2'd1);
    tick();
    redir(1'b0, 32'd0);
    instruction = BEQ;
    chk("tk_pred", 32'h108, 32'h10C, 32'h110, 1, 1, 1, 2'd2, 2'd3);
    tick();
    instruction = NOP;
    res(1'b1, 2'd2, 1'b1);
    chk("tk_next", 32'h110, 32'h114, 0, 1, 0, 0, 2'd0, 2'd1);
    tick();
    res(1'b1, 2'd2, 1'b0);
    chk("dec1", 32'h114, 32'h118, 0, 1, 0, 0, 2'd1, 2'd1);
    tick();
    chk("sat_hi", 32'h118, 32'h11C, 0, 1, 0, 0, 2'd2, 2'd2);
    tick();
    chk("dec3", 32'h11C, 32'h120, 0, 1, 0, 0, 2'd3, 2'd1);
    tick();
    chk("dec4", 32'h120, 32'h124, 0, 1, 0, 0, 2'd0, 2'd1);
    tick();
    res(1'b0, 2'd0, 1'b0);
    chk("seq124", 32'h124, 32'h128, 0, 1, 0, 0, 2'd1, 2'd1);
    tick();
    res(1'b1, 2'd0, 1'b1);
    chk("sat_lo", 32'h128, 32'h12C, 0, 1, 0, 0, 2'd2, 2'd0);
    tick();
    redir(1'b1, 32'h200);
    chk("to200", 32'h12C, 32'h130, 0, 1, 0, 0, 2'd3, 2'd1);
    tick();
    res(1'b0, 2'd0, 1'b0);
    redir(1'b0, 32'd0);
    instruction = BWD;
    stall = 1'b1;
    chk("stall_tk", 32'h200, 32'h204, 32'h1FC, 1, 1, 1, 2'd0, 2'd3);
    tick();
    stall = 1'b0;
    chk("bwd", 32'h200, 32'h204, 32'h1FC, 1, 1, 1, 2'd0, 2'd3);
    tick();
    instruction = NOP;
    stall = 1'b1;
    redir(1'b1, 32'h400);
    chk("bwd_next", 32'h1FC, 32'h200, 0, 1, 0, 0, 2'd3, 2'd1);
    tick();
    stall = 1'b0;
    redir(1'b0, 32'd0);
    res(1'b1, 2'd0, 1'b0);
    chk("same_old", 32'h400, 32'h404, 0, 1, 0, 0, 2'd0, 2'd3);
    tick();
    res(1'b0, 2'd0, 1'b0);
    redir(1'b1, 32'h400);
    chk("seq404", 32'h404, 32'h408, 0, 1, 0, 0, 2'd1, 2'd1);
    tick();
    redir(1'b1, 32'hFFFF_FFFC);
    chk("same_new", 32'h400, 32'h404, 0, 1, 0, 0, 2'd0, 2'd2);
    tick();
    redir(1'b0, 32'd0);
    chk("wrap_a", 32'hFFFF_FFFC, 32'h0, 0, 1, 0, 0, 2'd3, 2'd1);
    tick();
    redir(1'b1, 32'h200);
    chk("wrap_b", 32'h0, 32'h4, 0, 1, 0, 0, 2'd0, 2'd2);
    tick();
    instruction = BWD;
    redir(1'b1, 32'h300);
    chk("redir_tk", 32'h200, 32'h204, 32'h1FC, 1, 1, 1, 2'd0, 2'd2);
    tick();
    instruction = NOP;
    redir(1'b1, 32'h5A0);
    res(1'b1, 2'd1, 1'b1);
    chk("at300", 32'h300, 32'h304, 0, 1, 0, 0, 2'd0, 2'd2);
    tick();
    redir(1'b0, 32'd0);
    stall = 1'b1;
    chk("at5a0", 32'h5A0, 32'h5A4, 0, 1, 0, 0, 2'd0, 2'd2);
    tick();
    stall = 1'b0;
    instruction = BWD;
    redir(1'b1, 32'h778);
    res(1'b1, 2'd1, 1'b0);
    rst = 1'b0;
    chk("mid_rst", 32'h100, 32'h104, 0, 0, 0, 0, 2'd0, 2'd1);
    #6;
    rst = 1'b1;
    instruction = NOP;
    redir(1'b0, 32'd0);
    res(1'b0, 2'd0, 1'b0);
    tick();
    chk("rst_hold", 32'h100, 32'h104, 0, 1, 0, 0, 2'd0, 2'd1);
    tick();
    chk("rst_ctr", 32'h104, 32'h108, 0, 1, 0, 0, 2'd1, 2'd1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
